// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler: arbitrates periodic distance and on-demand level reports
// and sequences their ASCII bytes onto a shared UART transmitter via send/busy handshake.
module uart_report_scheduler #(
    parameter int REPORT_PERIOD = 10000000,
    parameter int DIST_W        = 33
) (
    input  logic              clk,
    input  logic              restart_n,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              lvl_req,
    input  logic [2:0]        lvl_code,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    output logic              msg_active,
    output logic              lvl_overrun
);
    localparam int TW = (REPORT_PERIOD > 2) ? $clog2(REPORT_PERIOD) : 1;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONV    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic          r_dist_pend;
    logic          r_lvl_pend;
    logic [2:0]    r_lvl_code;
    logic [2:0]    r_msg_code;
    logic          r_fav_lvl;
    logic          r_is_dist;
    logic [9:0]    r_rem;
    logic [3:0]    r_hund;
    logic [3:0]    r_tens;
    logic [2:0]    r_idx;
    logic [7:0]    r_tx_data;
    logic          r_overrun;
    logic          w_wrap;
    logic          w_grant;
    logic          w_take_lvl;
    logic          w_take_dist;
    logic          w_last;
    logic [9:0]    w_dist_sat;
    logic [2:0]    w_code_clamp;
    logic [7:0]    w_byte;
    always_comb begin
        w_wrap       = r_timer == TW'(REPORT_PERIOD - 1);
        w_grant      = (r_state == S_IDLE) && (r_dist_pend || r_lvl_pend);
        w_take_lvl   = w_grant && r_lvl_pend && (!r_dist_pend || r_fav_lvl);
        w_take_dist  = w_grant && !w_take_lvl;
        w_dist_sat   = (dist_in > DIST_W'(999)) ? 10'd999 : dist_in[9:0];
        w_code_clamp = (lvl_code > 3'd4) ? 3'd4 : lvl_code;
        w_last       = r_is_dist ? (r_idx == 3'd5) : (r_idx == 3'd3);
        // Byte layout: type letter, digit(s), then CR LF
        w_byte = (r_idx == 3'd0) ? (r_is_dist ? 8'h44 : 8'h4C)
               : (r_idx == 3'd1) ? 8'h30 + (r_is_dist ? {4'd0, r_hund} : {5'd0, r_msg_code})
               : (r_is_dist && r_idx == 3'd2) ? 8'h30 + {4'd0, r_tens}
               : (r_is_dist && r_idx == 3'd3) ? 8'h30 + {4'd0, r_rem[3:0]}
               : ((r_is_dist && r_idx == 3'd4) || (!r_is_dist && r_idx == 3'd2)) ? 8'h0D
               : 8'h0A;
    end
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_dist_pend <= 1'b0;
            r_lvl_pend  <= 1'b0;
            r_lvl_code  <= 3'd0;
            r_msg_code  <= 3'd0;
            r_fav_lvl   <= 1'b1;
            r_is_dist   <= 1'b0;
            r_rem       <= 10'd0;
            r_hund      <= 4'd0;
            r_tens      <= 4'd0;
            r_idx       <= 3'd0;
            r_tx_data   <= 8'h00;
            r_overrun   <= 1'b0;
        end else begin
            r_timer     <= w_wrap ? '0 : r_timer + 1'b1;
            r_dist_pend <= w_wrap | (r_dist_pend & ~w_take_dist);
            r_lvl_pend  <= lvl_req | (r_lvl_pend & ~w_take_lvl);
            if (lvl_req) begin
                r_lvl_code <= w_code_clamp;
                if (r_lvl_pend) r_overrun <= 1'b1;
            end
            // Round-robin pointer only moves on a contested grant
            if (w_grant && r_dist_pend && r_lvl_pend) r_fav_lvl <= ~w_take_lvl;
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_is_dist  <= w_take_dist;
                    r_msg_code <= r_lvl_code;
                    r_rem      <= w_dist_sat;
                    r_hund     <= 4'd0;
                    r_tens     <= 4'd0;
                    r_idx      <= 3'd0;
                    r_state    <= w_take_dist ? S_CONV : S_LOAD;
                end
                S_CONV: if (r_rem >= 10'd100) begin
                    r_rem  <= r_rem - 10'd100;
                    r_hund <= r_hund + 4'd1;
                end else if (r_rem >= 10'd10) begin
                    r_rem  <= r_rem - 10'd10;
                    r_tens <= r_tens + 4'd1;
                end else begin
                    r_state <= S_LOAD;
                end
                S_LOAD: if (!tx_busy) begin
                    r_tx_data <= w_byte;
                    r_state   <= S_SEND;
                end
                S_SEND:    r_state <= S_WAIT_HI;
                S_WAIT_HI: if (tx_busy) r_state <= S_WAIT_LO;
                S_WAIT_LO: if (!tx_busy) begin
                    r_idx   <= r_idx + 3'd1;
                    r_state <= w_last ? S_IDLE : S_LOAD;
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end
    assign tx_data     = r_tx_data;
    assign tx_send     = r_state == S_SEND;
    assign msg_active  = r_state != S_IDLE;
    assign lvl_overrun = r_overrun;
endmodule

// File: tb/tb_uart_report_scheduler.sv
// tb_uart_report_scheduler: message-level scoreboard with a busy-for-10-cycles transmitter
// model; directed phases followed by randomized distance values and level requests.
module tb_uart_report_scheduler;
    localparam int P = 100;
    logic        clk = 1'b0;
    logic        restart_n = 1'b0;
    logic [32:0] dist_in = '0;
    logic        lvl_req = 1'b0;
    logic [2:0]  lvl_code = 3'd0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        msg_active;
    logic        lvl_overrun;
    always #5 clk = ~clk;
    uart_report_scheduler #(.REPORT_PERIOD(P), .DIST_W(33)) dut (
        .clk(clk), .restart_n(restart_n), .dist_in(dist_in), .lvl_req(lvl_req),
        .lvl_code(lvl_code), .tx_busy(tx_busy), .tx_data(tx_data), .tx_send(tx_send),
        .msg_active(msg_active), .lvl_overrun(lvl_overrun)
    );
    int n_chk = 0;
    int n_fail = 0;
    bit m_dist, m_lvl, m_ovr, m_fav_lvl, m_cur_dist, prev_send;
    int m_code, n_edge, samp, exp_send, rem_bytes, busy_cnt, last_b;
    int exp_q[$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_dist = 0; m_lvl = 0; m_ovr = 0; m_fav_lvl = 1; m_cur_dist = 0; prev_send = 0;
        m_code = 0; n_edge = 0; exp_send = -1; rem_bytes = 0; busy_cnt = 0; last_b = 0;
        exp_q.delete();
        tx_busy = 0;
        lvl_req = 0;
    endtask
    // One clock: predict from the spec's rules, advance, then compare at the falling edge
    task automatic cycle();
        bit pre_act, req, wrap, any, tl, g, nd, nl;
        int v, s, c, eb;
        logic [32:0] d;
        pre_act = msg_active; req = lvl_req; d = dist_in;
        c = (lvl_code > 4) ? 4 : int'(lvl_code);
        n_edge++;
        wrap = (n_edge % P) == 0;
        any = m_dist | m_lvl;
        g = !pre_act && any;
        tl = m_lvl && (!m_dist || m_fav_lvl);
        @(posedge clk);
        @(negedge clk);
        samp++;
        if (!pre_act) chk("grant", 32'(msg_active), 32'(any));
        if (g) begin
            if (tl) begin
                exp_q.push_back('h4C); exp_q.push_back('h30 + m_code);
                s = 0; rem_bytes = 4;
            end else begin
                v = (d > 999) ? 999 : int'(d);
                exp_q.push_back('h44); exp_q.push_back('h30 + v / 100);
                exp_q.push_back('h30 + (v / 10) % 10); exp_q.push_back('h30 + v % 10);
                s = v / 100 + (v % 100) / 10 + 1; rem_bytes = 6;
            end
            exp_q.push_back('h0D); exp_q.push_back('h0A);
            if (m_dist && m_lvl) m_fav_lvl = !tl;
            m_cur_dist = !tl;
            exp_send = samp + s + 1;
        end
        nd = wrap || (m_dist && !(g && !tl));
        nl = req || (m_lvl && !(g && tl));
        if (req) begin
            if (m_lvl) m_ovr = 1;
            m_code = c;
        end
        m_dist = nd; m_lvl = nl;
        chk("overrun", 32'(lvl_overrun), 32'(m_ovr));
        if (pre_act && !msg_active) chk("drain", exp_q.size(), 0);
        chk("send_time", 32'(tx_send), 32'(samp == exp_send));
        if (tx_send) begin
            chk("back2back", 32'(prev_send), 0);
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 'h100;
            chk("byte", 32'(tx_data), eb);
            last_b = eb; busy_cnt = 10; tx_busy = 1; rem_bytes--; exp_send = -1;
        end else if (busy_cnt > 0) begin
            chk("hold", 32'(tx_data), last_b);
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy = 0;
                if (rem_bytes > 0) exp_send = samp + 2;
            end
        end
        prev_send = tx_send;
        lvl_req = 0;
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask
    task automatic pulse(input logic [2:0] code);
        lvl_code = code; lvl_req = 1; cycle();
    endtask
    initial begin
        int k;
        samp = 0;
        model_reset();
        #1;
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_send", 32'(tx_send), 0);
        chk("rst_active", 32'(msg_active), 0);
        chk("rst_ovr", 32'(lvl_overrun), 0);
        @(negedge clk); restart_n = 1;
        // Level request coincides with first timer wrap: level, then distance
        dist_in = 57;
        while (n_edge < P - 1) cycle();
        pulse(3'd3);
        chk("first_pair_lvl", 32'(m_cur_dist), 0);
        for (k = 0; k < 400 && !(msg_active && m_dist); k++) cycle();
        chk("bound_pair2", 32'(k < 400), 1);
        pulse(3'd2);
        run(250);
        dist_in = 257;  run(300);
        dist_in = 1500; run(300);
        dist_in = 0;    run(300);
        for (k = 0; k < 400 && (msg_active || m_dist || m_lvl); k++) cycle();
        chk("bound_idle1", 32'(k < 400), 1);
        pulse(3'd3); run(100);
        for (k = 0; k < 400 && (msg_active || m_dist || m_lvl); k++) cycle();
        chk("bound_idle2", 32'(k < 400), 1);
        pulse(3'd6); run(100);
        // Two level requests during one distance message
        for (k = 0; k < 400 && !(msg_active && m_cur_dist && !m_lvl && rem_bytes >= 5); k++) cycle();
        chk("bound_ovr", 32'(k < 400), 1);
        pulse(3'd1); run(3); pulse(3'd2);
        chk("overrun_set", 32'(lvl_overrun), 1);
        run(200);
        // Asynchronous reset in the middle of a distance message
        dist_in = 57;
        for (k = 0; k < 400 && !(msg_active && m_cur_dist); k++) cycle();
        chk("bound_rst", 32'(k < 400), 1);
        run(5);
        #2 restart_n = 0;
        #1;
        chk("arst_data", 32'(tx_data), 0);
        chk("arst_send", 32'(tx_send), 0);
        chk("arst_active", 32'(msg_active), 0);
        chk("arst_ovr", 32'(lvl_overrun), 0);
        @(negedge clk); @(negedge clk);
        model_reset();
        restart_n = 1;
        run(250);
        for (int i = 0; i < 2500; i++) begin
            dist_in = 33'($urandom_range(0, 1300));
            if ($urandom_range(0, 99) < 3) begin
                lvl_code = 3'($urandom_range(0, 7));
                lvl_req = 1;
            end
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_report_scheduler.md
# uart_report_scheduler

Schedules and sequences ASCII report messages onto the single shared byte-wide UART transmitter. Two requesters share it: a periodic distance report fed from the ultrasonic ranger, and an on-demand activity-level report fed from the LED level logic. The block arbitrates between them, converts the distance to three decimal digits, and drives the transmitter's send/busy handshake one byte at a time. It sits between the sensor/level logic and the UART TX instance.

## Interface
Parameters:
- REPORT_PERIOD, 10000000, clock cycles between automatic distance-report requests (100 ms at 100 MHz); must be ≥ 2
- DIST_W, 33, width of the distance input

Ports:
- clk  input  1  system clock, 100 MHz
- restart_n  input  1  asynchronous, active-low reset
- dist_in  input  DIST_W  distance in cm, unsigned
- lvl_req  input  1  one-cycle pulse: level report requested
- lvl_code  input  3  level value 0..4, sampled when lvl_req=1
- tx_busy  input  1  transmitter busy flag
- tx_data  output  8  byte to transmit, held stable from send until busy falls
- tx_send  output  1  one-cycle send strobe to transmitter
- msg_active  output  1  high while a message is being sequenced
- lvl_overrun  output  1  sticky: lvl_req arrived while a level report was still pending

## Operation
- Period timer: counts 0..REPORT_PERIOD-1, wraps; at wrap sets dist_pend. Setting an already-set dist_pend is silently absorbed.
- lvl_req=1: sets lvl_pend, latches lvl_code (values >4 clamp to 4). If lvl_pend already set: code overwritten, lvl_overrun←1 (cleared only by reset).
- Arbitration in IDLE only: one pending → take it; both pending → round-robin, with the type not served last winning; after reset, level wins first. Taking a request clears its pend bit in that cycle; a new request in the same cycle re-sets it.
- Distance message, 6 bytes: 'D'(0x44), hundreds, tens, ones ('0'+digit), CR(0x0D), LF(0x0A). dist_in is snapshotted on grant; values >999 saturate to 999.
- Level message, 4 bytes: 'L'(0x4C), '0'+code, CR, LF.
- States:
  - IDLE: wait for pend; grant → CONV (distance) or LOAD (level).
  - CONV: sequential subtraction, one step per cycle: subtract 100 while ≥100 (hundreds++), then 10 while ≥10 (tens++); remainder = ones. → LOAD.
  - LOAD: set tx_data to the current byte. → SEND.
  - SEND: tx_send=1 for exactly one cycle. → WAIT_HI.
  - WAIT_HI: wait for tx_busy=1. → WAIT_LO.
  - WAIT_LO: wait for tx_busy=0; last byte → IDLE, else byte index++ → LOAD.
- SEND is entered only when tx_busy=0. If tx_busy=1 in LOAD, the block holds in LOAD.
- msg_active=1 in every state except IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, tx_data=0x00, tx_send=0, msg_active=0, lvl_overrun=0, pend bits cleared, timer=0, round-robin pointer set to favour level.
- Reset mid-message aborts immediately; the partial message is not resumed.
- Grant to first tx_send: level 2 cycles (IDLE→LOAD→SEND); distance 2 + CONV steps (1..19 cycles; 0 → 1 step, 999 → 19 steps).
- Inter-byte: tx_busy fall → next tx_send after 2 cycles (WAIT_LO→LOAD→SEND).
- tx_data changes only in LOAD.
- tx_send never high in two consecutive cycles.
- Timer keeps running during messages; a wrap during a distance message queues exactly one further distance report.

## Test plan
- Reset asserted mid-message with dist_in=57 → all outputs return to reset values asynchronously; after release the next report starts cleanly from 'D'.
- REPORT_PERIOD=100, dist_in=257, model transmitter busy=10 cycles → bytes 0x44,0x32,0x35,0x37,0x0D,0x0A, one tx_send each, each send only after the previous busy falls.
- dist_in=1500 → bytes "D999" CR LF. dist_in=0 → "D000" CR LF, with first tx_send 3 cycles after grant.
- lvl_req with lvl_code=3 while idle → "L3" CR LF; lvl_code=6 → "L4" CR LF.
- lvl_req and timer wrap in the same cycle after reset → level message first, distance message immediately after; then a second simultaneous pair → distance first.
- Two lvl_req pulses (codes 1, then 2) during a distance message → lvl_overrun=1, exactly one "L2" CR LF sent afterwards.
